// File: rtl/scancode_decoder.sv
// scancode_decoder
// Turns raw PS/2 set-2 bytes from the keyboard controller into key events
// {extended, released, code}. The events are buffered in a first-word-fall-through
// FIFO that a CPU-side reader drains with a valid/ready handshake.
// kbd_valid is asynchronous to clk. It is synchronised, and then each rising edge
// becomes a one-cycle strobe that carries the sampled byte.
module scancode_decoder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    kbd_data,
  input  logic                          kbd_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_release,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SET_W = $clog2(SYNC_STAGES + 1);

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } event_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_PAUSE
  } state_t;

  // Controller replies (ACK, BAT result, echo, errors) are not key events.
  function automatic logic is_reply(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_reply = 1'b1;
      default:                                               is_reply = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Capture: synchroniser, edge detect, byte sample
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SET_W-1:0]       settle_cnt;
  logic                   settled;
  logic                   sync_last;
  logic                   prev_q;
  logic                   rise;
  logic                   strobe_r;
  logic [7:0]             byte_r;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign settled   = (settle_cnt == SET_W'(SYNC_STAGES));
  assign rise      = settled & sync_last & ~prev_q;

  // Shift kbd_valid through the synchroniser chain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], kbd_valid};
  end

  // Count the cycles the cleared chain needs to refill after reset.
  always_ff @(posedge clk) begin
    if (rst)           settle_cnt <= '0;
    else if (!settled) settle_cnt <= settle_cnt + SET_W'(1);
  end

  // Edge detect and byte sample. The previous-level flop is forced high until
  // the chain has refilled. This way a level that was held high across reset
  // is not seen as a new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= 1'b1;
      strobe_r <= 1'b0;
      byte_r   <= '0;
    end else begin
      prev_q   <= settled ? sync_last : 1'b1;
      strobe_r <= rise;
      if (rise) byte_r <= kbd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode FSM
  // ---------------------------------------------------------------------------
  state_t     state, state_n;
  logic [2:0] pause_cnt, pause_n;
  logic       push;
  event_t     push_ev;

  // State and pause-skip counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pause_cnt <= '0;
    end else begin
      state     <= state_n;
      pause_cnt <= pause_n;
    end
  end

  // Next-state and push decision. Each strobe moves the FSM exactly once.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_n = state;
    pause_n = pause_cnt;
    push    = 1'b0;
    push_ev = '0;
    if (strobe_r) begin
      case (state)
        S_IDLE: begin
          if (byte_r == 8'hE0) begin
            state_n = S_E0;
          end else if (byte_r == 8'hF0) begin
            state_n = S_F0;
          end else if (byte_r == 8'hE1) begin
            state_n = S_PAUSE;
            pause_n = 3'd7;
          end else if (!is_reply(byte_r)) begin
            push    = 1'b1;
            push_ev = '{ext: 1'b0, rel: 1'b0, code: byte_r};
          end
        end
        S_E0: begin
          if (byte_r == 8'hF0) begin
            state_n = S_E0F0;
          end else if (byte_r == 8'hE0) begin
            state_n = S_E0;
          end else begin
            state_n = S_IDLE;
            if (byte_r != 8'h12) begin
              push    = 1'b1;
              push_ev = '{ext: 1'b1, rel: 1'b0, code: byte_r};
            end
          end
        end
        S_F0: begin
          state_n = S_IDLE;
          push    = 1'b1;
          push_ev = '{ext: 1'b0, rel: 1'b1, code: byte_r};
        end
        S_E0F0: begin
          state_n = S_IDLE;
          if (byte_r != 8'h12) begin
            push    = 1'b1;
            push_ev = '{ext: 1'b1, rel: 1'b1, code: byte_r};
          end
        end
        S_PAUSE: begin
          pause_n = pause_cnt - 3'd1;
          if (pause_cnt == 3'd1) begin
            state_n = S_IDLE;
            push    = 1'b1;
            push_ev = '{ext: 1'b0, rel: 1'b0, code: 8'hE1};
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  event_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             do_push;
  event_t           head;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign ev_valid = (count != '0);
  assign pop      = ev_valid & ev_ready;
  // When the FIFO is full, a pop in the same cycle frees the slot for the push.
  assign do_push  = push & (~full | pop);

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Only the pointers and count need one,
    // and stale entries are masked at the outputs while the FIFO is empty.
    if (do_push) mem[wr_ptr] <= push_ev;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign ev_code    = ev_valid ? head.code : 8'h00;
  assign ev_ext     = ev_valid & head.ext;
  assign ev_release = ev_valid & head.rel;
  assign ev_count   = count;

endmodule

// File: tb/tb_scancode_decoder.sv
// tb_scancode_decoder
// Scoreboard bench. The stimulus sends PS/2 bytes, and a prefix-tracking reference
// model pushes the expected events into a queue. A monitor on the falling edge
// compares the DUT head, occupancy, valid and overflow against that queue, and it
// pops the queue whenever the DUT accepts a pop.
module tb_scancode_decoder;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic       ev_valid;
  logic       ev_ready;
  logic [$clog2(DEPTH):0] ev_count;
  logic       overflow;

  scancode_decoder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_release(ev_release),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_count(ev_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] exp_q[$];   // {ext, rel, code}
  logic       exp_ovf;
  int         ready_mode; // 0 low, 1 high, 2 random

  // Reference model state: pending prefixes and the remaining Pause bytes.
  bit m_ext, m_rel;
  int m_pause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reply_byte(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  endfunction

  // An event offered to the FIFO. It is dropped, and overflow is set, when all
  // DEPTH slots are still held after this cycle's pop.
  task automatic model_emit(input bit e, input bit r, input logic [7:0] c);
    if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else                        exp_q.push_back({e, r, c});
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) model_emit(1'b0, 1'b0, 8'hE1);
    end else if (m_rel) begin
      if (!(m_ext && b == 8'h12)) model_emit(m_ext, 1'b1, b);
      m_ext = 0; m_rel = 0;
    end else if (m_ext) begin
      if (b == 8'hF0)      m_rel = 1;
      else if (b != 8'hE0) begin
        if (b != 8'h12) model_emit(1'b1, 1'b0, b);
        m_ext = 0;
      end
    end else begin
      if (b == 8'hE0)       m_ext = 1;
      else if (b == 8'hF0)  m_rel = 1;
      else if (b == 8'hE1)  m_pause = 7;
      else if (!reply_byte(b)) model_emit(1'b0, 1'b0, b);
    end
  endtask

  // Send one byte. The rising edge is driven just after a clock edge, so the
  // event lands on the (SYNC+2)-th edge after it: SYNC synchroniser edges, one
  // strobe edge and one push edge. The model is updated right after that edge.
  // pulse_ready raises ev_ready only for the cycle that ends in the push.
  task automatic send_byte(input logic [7:0] b, input bit pulse_ready = 1'b0);
    @(posedge clk); #2;
    kbd_data  = b;
    kbd_valid = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    if (pulse_ready) begin #1; ready_mode = 1; end
    @(posedge clk); #1;
    model_byte(b);
    if (pulse_ready) ready_mode = 0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #2;
    kbd_valid = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
  endtask

  task automatic do_reset(input bit hold_high);
    @(posedge clk); #2;
    rst = 1'b1;
    if (hold_high) begin
      kbd_data  = 8'h33;
      kbd_valid = 1'b1;
    end
    exp_q.delete();
    exp_ovf = 1'b0;
    m_ext = 0; m_rel = 0; m_pause = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",   ev_valid,   1'b0);
    check("rst_count",   ev_count,   0);
    check("rst_ovf",     overflow,   1'b0);
    check("rst_code",    ev_code,    8'h00);
    check("rst_ext",     ev_ext,     1'b0);
    check("rst_release", ev_release, 1'b0);
    #1 rst = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
  endtask

  task automatic drain(input string name);
    ready_mode = 1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // ev_ready driver.
  initial begin
    ev_ready = 1'b0;
    forever begin
      @(posedge clk); #3;
      case (ready_mode)
        0:       ev_ready = 1'b0;
        1:       ev_ready = 1'b1;
        default: ev_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares the DUT against the scoreboard and pops on an accepted head.
  always @(negedge clk) begin
    if (!rst) begin
      check("count", ev_count, exp_q.size());
      check("valid", ev_valid, exp_q.size() != 0);
      check("ovf",   overflow, exp_ovf);
      if (exp_q.size() != 0) begin
        check("head", {ev_ext, ev_release, ev_code}, exp_q[0]);
        if (ev_valid && ev_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] seq_pause [8];
    logic [7:0] replies   [8];
    rst        = 1'b1;
    kbd_data   = 8'h00;
    kbd_valid  = 1'b0;
    ready_mode = 1;
    exp_ovf    = 1'b0;
    seq_pause  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    replies    = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    do_reset(1'b0);

    // Single make code, then break, extended make and extended break.
    ready_mode = 0;
    send_byte(8'h1C);
    repeat (3) @(posedge clk);
    drain("drain_single");
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    drain("drain_prefix");

    // Pause sequence, controller replies, fake shifts and a repeated E0.
    foreach (seq_pause[i]) send_byte(seq_pause[i]);
    send_byte(8'hAA); send_byte(8'hFA);
    send_byte(8'hE0); send_byte(8'h12);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h6B);
    send_byte(8'hF0); send_byte(8'h12);
    drain("drain_pause");

    // Overflow: DEPTH+1 make codes with the reader stalled.
    ready_mode = 0;
    for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i));
    check("ovf_set", overflow, 1'b1);
    drain("drain_ovf");

    // A push into a full FIFO together with a pop is accepted.
    do_reset(1'b0);
    ready_mode = 0;
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i));
    send_byte(8'h18, 1'b1);
    check("full_pp_count", ev_count, DEPTH);
    drain("drain_full_pp");

    // Reset between E0 and its code, then a level held high across reset.
    send_byte(8'hE0);
    do_reset(1'b0);
    ready_mode = 0;
    send_byte(8'h75);
    check("post_rst_count", ev_count, 1);
    drain("drain_post_rst");
    do_reset(1'b1);
    repeat (8) @(posedge clk);
    check("held_no_event", ev_count, 0);
    #2 kbd_valid = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    send_byte(8'h2A);
    drain("drain_after_held");

    // Randomised byte streams with a random reader.
    ready_mode = 2;
    for (int n = 0; n < 200; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 15);
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h5A;
        5:       b = replies[$urandom_range(0, 7)];
        6:       b = 8'h12;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_byte(b);
    end
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
